// File: rtl/sim_mon_pkg.sv
// Shared types and trace-record layout helpers for the commit/trace monitor.
// A record is packed as {cycle, pc, rd, data}, with data in the low bits.
package sim_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } monState_t;

  localparam int DATA_LSB = 0;

  function automatic int recWidth(input int xlen, input int regAw, input int cw);
    return cw + 2 * xlen + regAw;
  endfunction

  function automatic int rdLsb(input int xlen);
    return xlen;
  endfunction

  function automatic int pcLsb(input int xlen, input int regAw);
    return xlen + regAw;
  endfunction

  function automatic int cycleLsb(input int xlen, input int regAw);
    return 2 * xlen + regAw;
  endfunction

endpackage

// File: rtl/sim_trace_monitor_if.sv
// Trace record stream: the monitor (master) presents the FIFO head, and the
// consumer (slave) accepts it with trc_ready_i.
interface sim_trace_monitor_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CW     = 32
);
  logic              trc_valid_o;
  logic              trc_ready_i;
  logic [CW-1:0]     trc_cycle_o;
  logic [XLEN-1:0]   trc_pc_o;
  logic [REG_AW-1:0] trc_rd_o;
  logic [XLEN-1:0]   trc_data_o;

  modport master (
    output trc_valid_o, trc_cycle_o, trc_pc_o, trc_rd_o, trc_data_o,
    input  trc_ready_i
  );

  modport slave (
    input  trc_valid_o, trc_cycle_o, trc_pc_o, trc_rd_o, trc_data_o,
    output trc_ready_i
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO. The head entry is readable while !empty, and a
// push into a full FIFO is accepted only when a pop frees a slot that cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/sim_trace_monitor.sv
// Commit/trace monitor: records register writebacks into a FIFO, detects program
// end from a run of zero instructions (or a watchdog), drains, then reports halted.
module sim_trace_monitor
  import sim_mon_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int DEPTH        = 16,
  parameter int CW           = 32,
  parameter int HALT_ZEROS   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_CYCLES   = 0,
  parameter bit TRACE_X0     = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              instr_valid_i,
  input  logic [31:0]       instr_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic [XLEN-1:0]   wb_pc_i,
  sim_trace_monitor_if.master trc,
  output logic [CW-1:0]     cycle_count_o,
  output logic              busy_o,
  output logic              halted_o,
  output logic              timeout_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o
);
  localparam int RW        = recWidth(XLEN, REG_AW, CW);
  localparam int RD_LSB    = rdLsb(XLEN);
  localparam int PC_LSB    = pcLsb(XLEN, REG_AW);
  localparam int CYCLE_LSB = cycleLsb(XLEN, REG_AW);
  localparam int ZW        = (HALT_ZEROS > 1) ? $clog2(HALT_ZEROS + 1) : 1;
  localparam int DW        = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  monState_t         state;
  logic [CW-1:0]     cycleCount;
  logic [ZW-1:0]     zeroRun;
  logic [DW-1:0]     drainCnt;
  logic              timeoutFlag;
  logic              overflowFlag;
  logic [15:0]       dropCount;

  logic              zeroHit;
  logic              wdHit;
  logic              captureEn;
  logic              pushReq;
  logic              popFire;
  logic              dropEv;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [RW-1:0]     wrRec;
  logic [RW-1:0]     headRec;

  assign zeroHit   = (state == RUN) && instr_valid_i && (instr_i == '0)
                     && (zeroRun == ZW'(HALT_ZEROS - 1));
  assign wdHit     = (state == RUN) && (MAX_CYCLES != 0)
                     && (cycleCount == CW'(MAX_CYCLES - 1));
  assign captureEn = (state == RUN) || ((state == DRAIN) && (drainCnt != '0));
  assign pushReq   = captureEn && wb_valid_i && ((wb_rd_i != '0) || TRACE_X0);
  assign popFire   = !fifoEmpty && trc.trc_ready_i;
  assign dropEv    = pushReq && fifoFull && !popFire;
  assign wrRec     = {cycleCount, wb_pc_i, wb_rd_i, wb_data_i};

  trace_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (pushReq),
    .pop    (popFire),
    .wrData (wrRec),
    .rdData (headRec),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  // Zero-run halt wins over the watchdog when both fire in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cycleCount   <= '0;
      zeroRun      <= '0;
      drainCnt     <= '0;
      timeoutFlag  <= 1'b0;
      overflowFlag <= 1'b0;
      dropCount    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state        <= RUN;
            cycleCount   <= '0;
            zeroRun      <= '0;
            dropCount    <= '0;
            timeoutFlag  <= 1'b0;
            overflowFlag <= 1'b0;
          end
        end
        RUN: begin
          if (cycleCount != '1) cycleCount <= cycleCount + 1'b1;
          if (instr_valid_i) zeroRun <= (instr_i == '0) ? zeroRun + 1'b1 : '0;
          if (zeroHit || wdHit) begin
            state       <= DRAIN;
            drainCnt    <= DW'(DRAIN_CYCLES);
            timeoutFlag <= !zeroHit;
          end
        end
        DRAIN: begin
          if (cycleCount != '1) cycleCount <= cycleCount + 1'b1;
          if (drainCnt != '0) drainCnt <= drainCnt - 1'b1;
          else if (fifoEmpty) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (dropEv) begin
        overflowFlag <= 1'b1;
        if (dropCount != 16'hFFFF) dropCount <= dropCount + 1'b1;
      end
    end
  end

  // Head fields read as zero while empty so every output is clean after reset.
  assign trc.trc_valid_o = !fifoEmpty;
  assign trc.trc_cycle_o = fifoEmpty ? '0 : headRec[CYCLE_LSB +: CW];
  assign trc.trc_pc_o    = fifoEmpty ? '0 : headRec[PC_LSB +: XLEN];
  assign trc.trc_rd_o    = fifoEmpty ? '0 : headRec[RD_LSB +: REG_AW];
  assign trc.trc_data_o  = fifoEmpty ? '0 : headRec[DATA_LSB +: XLEN];

  assign cycle_count_o = cycleCount;
  assign busy_o        = (state == RUN) || (state == DRAIN);
  assign halted_o      = (state == DONE);
  assign timeout_o     = timeoutFlag;
  assign overflow_o    = overflowFlag;
  assign drop_count_o  = dropCount;

endmodule

// File: doc/sim_trace_monitor.md
Name: sim_trace_monitor

Overview:
Synthesizable commit/trace monitor that sits beside the pipelined RISC-V CPU and taps its decode-stage instruction and writeback port. It buffers register-write records {cycle, pc, rd, data} in a parametrised FIFO and streams them out over a valid/ready port. It detects program end after HALT_ZEROS consecutive all-zero instructions, with an optional cycle-limit watchdog. It then drains the pipeline and raises halted_o, replacing ad-hoc bench-side polling.

Parameters:
XLEN, 32, register/PC/data width
REG_AW, 5, register address width (2**REG_AW registers)
DEPTH, 16, trace FIFO entries; power of two, >=2
CW, 32, cycle counter width
HALT_ZEROS, 1, consecutive valid zero instructions that trigger halt; >=1
DRAIN_CYCLES, 3, cycles after halt trigger during which writebacks are still captured
MAX_CYCLES, 0, watchdog limit in RUN cycles; 0 disables
TRACE_X0, 0, 1 = also record writes to x0

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active low
start_i  in  1  begin monitoring; sampled in IDLE and DONE only
instr_valid_i  in  1  instr_i is a real (non-stalled) decode-stage instruction this cycle
instr_i  in  32  decode-stage instruction
wb_valid_i  in  1  register write committing this cycle
wb_rd_i  in  REG_AW  destination register
wb_data_i  in  XLEN  write data
wb_pc_i  in  XLEN  PC of the committing instruction
trc_valid_o  out  1  FIFO head valid
trc_ready_i  in  1  consumer accepts head
trc_cycle_o  out  CW  head: cycle count at capture
trc_pc_o  out  XLEN  head: PC
trc_rd_o  out  REG_AW  head: rd
trc_data_o  out  XLEN  head: data
cycle_count_o  out  CW  current RUN/DRAIN cycle count
busy_o  out  1  state is RUN or DRAIN
halted_o  out  1  state is DONE
timeout_o  out  1  sticky: halt caused by watchdog
overflow_o  out  1  sticky: at least one record dropped
drop_count_o  out  16  saturating dropped-record count

Behaviour:
- Reset (rst_i==0 at a rising edge): state IDLE; FIFO emptied; all counters and sticky flags 0. Every output is 0 the following cycle. Reset mid-run discards buffered records.
- FSM: IDLE -> RUN on start_i. RUN -> DRAIN when the zero-run reaches HALT_ZEROS, or when MAX_CYCLES!=0 and cycle_count reaches MAX_CYCLES-1. DRAIN -> DONE when the drain counter reaches 0 and the FIFO is empty. DONE -> RUN on start_i.
- Entering RUN: cycle_count, zero_run, drop_count, timeout_o and overflow_o are cleared.
- cycle_count increments every RUN/DRAIN cycle and saturates at all-ones.
- zero_run in RUN, when instr_valid_i==1: increments if instr_i==0, otherwise clears. When instr_valid_i==0 it holds (stalls do not break a run).
- Halt and watchdog in the same cycle: timeout_o=0; zero-halt has priority.
- On entering DRAIN, the drain counter loads DRAIN_CYCLES. Capture stays enabled while the counter is nonzero; it decrements each DRAIN cycle. With DRAIN_CYCLES=0, capture stops immediately.
- Capture: a push is requested when capture is enabled and wb_valid_i==1 and (wb_rd_i!=0 or TRACE_X0). Capture is enabled in RUN, including the trigger cycle, and in DRAIN while the drain counter is nonzero.
- FIFO: show-ahead; trc_valid_o = !empty; head fields are registered storage. A record pushed in cycle N is visible in cycle N+1.
- Pop on trc_valid_o && trc_ready_i.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Push is dropped when full with no pop: overflow_o set, drop_count_o incremented (saturates at 16'hFFFF).
- Simultaneous push and pop while empty: push accepted, no pop (valid was 0).
- Pointers are REG-free of width log2(DEPTH)+1 and wrap naturally; full/empty come from the MSB compare.
- trc_ready_i is ignored when empty. Output fields are don't-care when trc_valid_o==0, but are held stable while valid && !ready.
- In DONE the FIFO stays empty and further wb/instr activity is ignored.

Decomposition:
- Package sim_mon_pkg: FSM state localparams (IDLE, RUN, DRAIN, DONE) and the trace-record width/field offset constants derived from XLEN, REG_AW and CW.
- Sub-module trace_fifo: parametrised width/depth sync FIFO with push/pop/full/empty and a show-ahead head. The top holds the FSM, counters and flags.

Test Plan:
- Reset then start_i; writebacks x5=7 @pc 0x10008, x0=9 @0x1000C, x6=-1 @0x10010 with trc_ready_i=1 -> two records (x5,7),(x6,0xFFFFFFFF), each one cycle after capture; x0 write absent.
- HALT_ZEROS=2: instr 0, stall (instr_valid_i=0), 0 -> DRAIN on the second zero; a writeback 2 cycles later is captured; halted_o=1 after DRAIN_CYCLES plus drain of the FIFO.
- trc_ready_i=0, DEPTH=16, 20 writebacks -> 16 retained in order, overflow_o=1, drop_count_o=4. Then a full-with-pop cycle -> push accepted, no drop.
- MAX_CYCLES=50 with no zero instruction -> DRAIN at cycle_count 49, timeout_o=1, halted_o once empty. Restart via start_i -> flags cleared, cycle_count=0.
- Reset asserted mid-RUN with 5 buffered records -> next cycle trc_valid_o=0, busy_o=0, counters 0. Start resumes cleanly.
- Backpressure toggling ready every cycle with a push every cycle over 100 cycles -> no loss/duplication, pointers wrap, order preserved versus the scoreboard.
